// File: rtl/vga_tile_scanner.sv
// vga_tile_scanner: scans a 32x32 tile framebuffer through a synchronous
// read port and drives VGA rgb/hsync/vsync, plus a vertical-blank interrupt.
// Each framebuffer word becomes one TILE_W x TILE_H block of pixels.
module vga_tile_scanner #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int TILE_W     = 20,
  parameter int TILE_H     = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] dispAddr,
  input  logic [DATA_WIDTH-1:0] dispColor,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  vblank_irq,
  input  logic                  irq_ack
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int DW  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int TXW = (TILE_W > 2) ? $clog2(TILE_W) : 1;
  localparam int TYW = (TILE_H > 2) ? $clog2(TILE_H) : 1;
  localparam int GW  = ADDR_WIDTH / 2;

  localparam logic [DW-1:0]  DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0]  H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]  H_ACT     = HW'(H_ACTIVE);
  localparam logic [HW-1:0]  HS_FIRST  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]  HS_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0]  V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]  V_ACT     = VW'(V_ACTIVE);
  localparam logic [VW-1:0]  V_IRQ     = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0]  VS_FIRST  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]  VS_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [TXW-1:0] TX_LAST   = TXW'(TILE_W - 1);
  localparam logic [TYW-1:0] TY_LAST   = TYW'(TILE_H - 1);
  localparam logic [GW-1:0]  GRID_LAST = {GW{1'b1}};

  logic [DW-1:0]  div;
  logic [HW-1:0]  h;
  logic [VW-1:0]  v;
  logic [TXW-1:0] tx;
  logic [TYW-1:0] ty;
  logic [GW-1:0]  col;
  logic [GW-1:0]  row;
  logic [11:0]    rgb;
  logic           tick;
  logic           active;
  logic           unused_color;

  // Tile index advances but sticks at the last column/row of the grid.
  function automatic logic [GW-1:0] sat_inc(input logic [GW-1:0] x);
    return (x == GRID_LAST) ? x : x + GW'(1);
  endfunction

  assign tick         = (div == DIV_LAST);
  assign active       = (h < H_ACT) && (v < V_ACT);
  assign dispAddr     = {row, col};
  assign vga_r        = rgb[11:8];
  assign vga_g        = rgb[7:4];
  assign vga_b        = rgb[3:0];
  assign unused_color = ^dispColor[DATA_WIDTH-1:12];

  // Pixel clock divider: one tick every CLK_DIV clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div <= '0;
    else     div <= tick ? '0 : div + DW'(1);
  end

  // Raster position and tile coordinates, advanced once per pixel tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h   <= '0;
      v   <= '0;
      tx  <= '0;
      ty  <= '0;
      col <= '0;
      row <= '0;
    end else if (tick) begin
      if (h == H_LAST) begin
        h   <= '0;
        tx  <= '0;
        col <= '0;
        if (v == V_LAST) begin
          v   <= '0;
          ty  <= '0;
          row <= '0;
        end else begin
          v <= v + VW'(1);
          if (v < V_ACT) begin
            if (ty == TY_LAST) begin
              ty  <= '0;
              row <= sat_inc(row);
            end else begin
              ty <= ty + TYW'(1);
            end
          end
        end
      end else begin
        h <= h + HW'(1);
        if (h < H_ACT) begin
          if (tx == TX_LAST) begin
            tx  <= '0;
            col <= sat_inc(col);
          end else begin
            tx <= tx + TXW'(1);
          end
        end
      end
    end
  end

  // Output stage: colour and syncs of the pixel just scanned, one pixel late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (tick) begin
      rgb   <= active ? dispColor[11:0] : 12'h000;
      hsync <= ~((h >= HS_FIRST) && (h <= HS_LAST));
      vsync <= ~((v >= VS_FIRST) && (v <= VS_LAST));
    end
  end

  // Vertical-blank request: set entering the first blank line, cleared by ack; set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   vblank_irq <= 1'b0;
    else if (tick && h == H_LAST && v == V_IRQ) vblank_irq <= 1'b1;
    else if (irq_ack)                          vblank_irq <= 1'b0;
  end

endmodule

// File: doc/vga_tile_scanner.md
# vga_tile_scanner

Display scan engine that reads the CPU's video framebuffer through its read-only display port and drives a 640x480@60 Hz VGA output. It generates the display address, consumes the returned 32-bit word, expands each word into a 20x15-pixel tile (32x32 tile grid = 1024 words), and produces active-low sync signals. It also raises a vertical-blank interrupt request so the pipeline's interrupt logic can update the framebuffer during blanking.

## Interface
Parameters:
- ADDR_WIDTH, 10, framebuffer word-address width; must equal 2*log2 of the 32-tile grid dimension.
- DATA_WIDTH, 32, framebuffer word width; colour is taken from bits [11:0].
- CLK_DIV, 4, clk cycles per pixel; must be ≥2.
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels (total 800).
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines (total 525).
- TILE_W, 20, pixels per tile column; TILE_H, 15, lines per tile row.

Ports:
- clk  in  1  single clock, rising edge; all logic runs on it. The framebuffer display port uses this same clock.
- rst  in  1  asynchronous, active-high reset.
- dispAddr  out  ADDR_WIDTH  framebuffer display-port word address.
- dispColor  in  DATA_WIDTH  framebuffer data; valid one clk after dispAddr changes (synchronous read).
- vga_r, vga_g, vga_b  out  4 each  colour = dispColor[11:8], [7:4], [3:0].
- hsync, vsync  out  1 each  active-low sync.
- vblank_irq  out  1  level interrupt request; set at vblank start.
- irq_ack  in  1  clears vblank_irq.

## Operation
- Reset (async): div=0, h=0, v=0, tile col/row and sub-counters=0, dispAddr=0, rgb=0, hsync=1, vsync=1, vblank_irq=0. Deasserting rst mid-frame restarts at pixel (0,0); there is no partial-frame recovery.
- Pixel tick: div counts 0..CLK_DIV-1 and wraps; tick = (div==CLK_DIV-1). All scan state advances only on tick.
- h counts 0..799; on h==799 it wraps to 0 and v increments; v counts 0..524 and wraps to 0 when h and v are both at their maxima.
- Tile column: tx counts 0..TILE_W-1 while h<H_ACTIVE. On tx wrap, col increments, saturating at 31. On h wrap, tx=0 and col=0.
- Tile row: at each h wrap with v<V_ACTIVE, ty counts 0..TILE_H-1. On ty wrap, row increments, saturating at 31. On frame wrap, ty=0 and row=0.
- dispAddr = row*32 + col, driven directly from registered row/col, so it changes only on the clk following a tick. During blanking it holds its last value.
- Output stage, registered on tick, one-pixel delay:
  - rgb <= active_prev ? dispColor[11:0] : 0, where active_prev = (h<H_ACTIVE && v<V_ACTIVE) for the previous pixel position.
  - hsync <= ~(h_prev in [656,751]).
  - vsync <= ~(v_prev in [490,491]).
- IRQ: vblank_irq is set on the tick where v advances from 479 to 480. It is cleared on any clk where irq_ack=1. If set and ack occur in the same cycle, set wins. If the IRQ is already set, the next set keeps it at 1; there is no counting.
- Colour bits [31:12] of dispColor are ignored.

## Timing
- Address-to-data: dispAddr is stable for CLK_DIV clks; dispColor is sampled CLK_DIV clks after the address change, which leaves CLK_DIV-1 clks of slack.
- Pixel (h,v) appears on the outputs at the tick for h+1. hsync, vsync and rgb share the same one-pixel delay, so their mutual alignment is exact.
- Frame = 800*525*CLK_DIV clks (1,680,000 at default).
- vblank_irq rises on the clk after the tick that enters line 480. It falls on the clk after irq_ack is sampled high.

## Test plan
- Reset: hold rst for 3 clks mid-frame → all outputs at their reset values immediately (async). First tick after release has h=1, and dispAddr=0.
- Tile addressing: framebuffer model with word[i]=i → pixel (0..19, line 0) outputs rgb=0x000; pixels (20..39, lines 15..29) output 0x021 (word 33); pixel (639, 479) outputs 0x3FF (word 1023).
- Blanking: during h=640..799 → rgb=0 even with framebuffer all 0xFFF. hsync low for exactly 96 ticks starting at output tick for h=657. vsync low for exactly 2 lines (490–491).
- Frame period: measure vsync falling edges → exactly 1,680,000 clks apart at CLK_DIV=4.
- IRQ handshake: vblank_irq rises at line 480. Pulse irq_ack 1 clk → irq falls next clk. Hold irq_ack high across the set tick → irq=1 (set wins).
- CLK_DIV=2 variant: same tile image is correct, confirming the one-clk read latency is met.
